// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_pkg
// Purpose  : Shared pipeline definitions for the MEM/WB stage: access FSM
//            state encoding and the default memory-access timeout.
// Revision : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

  // Access FSM state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_HALTED = 2'd2
  } mem_state_t;

  // Default bound on how many cycles one data-memory access may be outstanding
  localparam int c_mem_timeout_default = 16;

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_memwb_reg.sv
`default_nettype none
// ============================================================================
// Module   : memwb_reg
// Purpose  : MEM/WB pipeline register bank. Loads when enabled; a bubble
//            clears the control bits while data and destination hold.
// Revision : 1.0 - initial release
// ============================================================================
module memwb_reg (
  input  logic        clk,
  input  logic        rst,         // asynchronous, active-low
  input  logic        load_en,
  input  logic        bubble,
  input  logic [15:0] d_data,
  input  logic [2:0]  d_rd,
  input  logic        d_regwrite,
  input  logic        d_halt,
  input  logic        d_err,
  output logic [15:0] q_data,
  output logic [2:0]  q_rd,
  output logic        q_regwrite,
  output logic        q_halt,
  output logic        q_err
);

  logic [15:0] r_data;
  logic [2:0]  r_rd;
  logic        r_regwrite;
  logic        r_halt;
  logic        r_err;

  // Pipeline register: clear on reset, bubble or full load when enabled, else hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= 16'h0000;
      r_rd       <= 3'd0;
      r_regwrite <= 1'b0;
      r_halt     <= 1'b0;
      r_err      <= 1'b0;
    end else if (load_en) begin
      if (bubble) begin
        r_regwrite <= 1'b0;
        r_halt     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        r_data     <= d_data;
        r_rd       <= d_rd;
        r_regwrite <= d_regwrite;
        r_halt     <= d_halt;
        r_err      <= d_err;
      end
    end
  end

  assign q_data     = r_data;
  assign q_rd       = r_rd;
  assign q_regwrite = r_regwrite;
  assign q_halt     = r_halt;
  assign q_err      = r_err;

endmodule : memwb_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory stage with a variable-latency data-memory handshake,
//            stall generation, access timeout and the MEM/WB write-back mux.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = c_mem_timeout_default
) (
  input  logic        clk,
  input  logic        rst,              // asynchronous, active-low
  // EX/MEM side
  input  logic [15:0] ALU_Out_EXMEM,
  input  logic [15:0] pcAdd2_EXMEM,
  input  logic [15:0] read2Data_EXMEM,
  input  logic [2:0]  RegisterRd_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        pc_to_reg_EXMEM,
  input  logic        Halt_EXMEM,
  input  logic        err_EXMEM,
  // Data memory
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_done,
  input  logic        dmem_err,
  // Pipeline outputs
  output logic        stall_mem,
  output logic [15:0] wb_data_MEMWB,
  output logic [2:0]  RegisterRd_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        Halt_MEMWB,
  output logic        err_MEMWB
);

  localparam int c_cnt_w = $clog2(MEM_TIMEOUT) + 1;
  // Timeout fires in the cycle whose increment would bring the counter to
  // MEM_TIMEOUT-1, so an access is outstanding at most MEM_TIMEOUT cycles.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 2);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

  mem_state_t         r_state;
  mem_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;

  logic        w_active;
  logic        w_access;
  logic        w_timeout;
  logic        w_req;
  logic        w_retire;
  logic [15:0] w_wb_data;
  logic        w_err_nxt;
  logic        w_halt_nxt;
  logic        w_regwrite_nxt;

  // Qualifiers: a halted or in-reset stage never requests memory or stalls
  assign w_active  = rst & (r_state != ST_HALTED);
  assign w_access  = (MemRead_EXMEM | MemWrite_EXMEM) & ~Halt_EXMEM & ~err_EXMEM;
  assign w_timeout = w_active & (r_state == ST_BUSY) & w_access & ~dmem_done &
                     (r_cnt >= c_cnt_last);
  assign w_req     = w_active & w_access & ~w_timeout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Wait counter: cleared while idle, saturating count while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        r_cnt <= '0;
    else if (r_state == ST_IDLE)                     r_cnt <= '0;
    else if (r_state == ST_BUSY && r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
  end

  // Next-state logic; a retiring halt or error (including timeout) is terminal
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_retire)                    w_state_nxt = ST_HALTED;
        else if (w_access && !dmem_done) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_retire)                    w_state_nxt = ST_HALTED;
        else if (!w_access || dmem_done) w_state_nxt = ST_IDLE;
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: memory request levels and stall while an access is pending
  always_comb begin
    dmem_rd    = w_req & MemRead_EXMEM;
    dmem_wr    = w_req & MemWrite_EXMEM;
    dmem_addr  = w_req ? ALU_Out_EXMEM   : 16'h0000;
    dmem_wdata = w_req ? read2Data_EXMEM : 16'h0000;
    stall_mem  = w_req & ~dmem_done;
  end

  // Write-back mux and MEM/WB control values; timeout overrides with an error
  always_comb begin
    if (pc_to_reg_EXMEM)     w_wb_data = pcAdd2_EXMEM;
    else if (MemtoReg_EXMEM) w_wb_data = dmem_rdata;
    else                     w_wb_data = ALU_Out_EXMEM;
    w_err_nxt      = w_timeout | err_EXMEM | (w_access & dmem_err);
    w_halt_nxt     = ~w_timeout & Halt_EXMEM;
    w_regwrite_nxt = RegWrite_EXMEM & ~w_err_nxt;
    w_retire       = w_active & ~stall_mem & (w_halt_nxt | w_err_nxt);
  end

  memwb_reg u_memwb_reg (
    .clk        (clk),
    .rst        (rst),
    .load_en    (w_active),
    .bubble     (stall_mem),
    .d_data     (w_wb_data),
    .d_rd       (RegisterRd_EXMEM),
    .d_regwrite (w_regwrite_nxt),
    .d_halt     (w_halt_nxt),
    .d_err      (w_err_nxt),
    .q_data     (wb_data_MEMWB),
    .q_rd       (RegisterRd_MEMWB),
    .q_regwrite (RegWrite_MEMWB),
    .q_halt     (Halt_MEMWB),
    .q_err      (err_MEMWB)
  );

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Directed self-checking bench for mem_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [15:0] ALU_Out_EXMEM, pcAdd2_EXMEM, read2Data_EXMEM;
  logic [2:0]  RegisterRd_EXMEM;
  logic        MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, RegWrite_EXMEM;
  logic        pc_to_reg_EXMEM, Halt_EXMEM, err_EXMEM;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_rd, dmem_wr, dmem_done, dmem_err;
  logic        stall_mem;
  logic [15:0] wb_data_MEMWB;
  logic [2:0]  RegisterRd_MEMWB;
  logic        RegWrite_MEMWB, Halt_MEMWB, err_MEMWB;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage #(.MEM_TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .ALU_Out_EXMEM    (ALU_Out_EXMEM),
    .pcAdd2_EXMEM     (pcAdd2_EXMEM),
    .read2Data_EXMEM  (read2Data_EXMEM),
    .RegisterRd_EXMEM (RegisterRd_EXMEM),
    .MemtoReg_EXMEM   (MemtoReg_EXMEM),
    .MemRead_EXMEM    (MemRead_EXMEM),
    .MemWrite_EXMEM   (MemWrite_EXMEM),
    .RegWrite_EXMEM   (RegWrite_EXMEM),
    .pc_to_reg_EXMEM  (pc_to_reg_EXMEM),
    .Halt_EXMEM       (Halt_EXMEM),
    .err_EXMEM        (err_EXMEM),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rd          (dmem_rd),
    .dmem_wr          (dmem_wr),
    .dmem_rdata       (dmem_rdata),
    .dmem_done        (dmem_done),
    .dmem_err         (dmem_err),
    .stall_mem        (stall_mem),
    .wb_data_MEMWB    (wb_data_MEMWB),
    .RegisterRd_MEMWB (RegisterRd_MEMWB),
    .RegWrite_MEMWB   (RegWrite_MEMWB),
    .Halt_MEMWB       (Halt_MEMWB),
    .err_MEMWB        (err_MEMWB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ALU_Out_EXMEM    = 16'h0000;
    pcAdd2_EXMEM     = 16'h0000;
    read2Data_EXMEM  = 16'h0000;
    RegisterRd_EXMEM = 3'd0;
    MemtoReg_EXMEM   = 1'b0;
    MemRead_EXMEM    = 1'b0;
    MemWrite_EXMEM   = 1'b0;
    RegWrite_EXMEM   = 1'b0;
    pc_to_reg_EXMEM  = 1'b0;
    Halt_EXMEM       = 1'b0;
    err_EXMEM        = 1'b0;
    dmem_rdata       = 16'h0000;
    dmem_done        = 1'b0;
    dmem_err         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int stall_cnt;
    rst = 1'b0;
    clear_inputs();
    // Request pending during reset must be suppressed
    MemRead_EXMEM = 1'b1;
    ALU_Out_EXMEM = 16'h0040;
    #3;
    check("rst_dmem_rd",   {15'd0, dmem_rd},        16'h0);
    check("rst_stall",     {15'd0, stall_mem},      16'h0);
    check("rst_wb_data",   wb_data_MEMWB,           16'h0);
    check("rst_regwrite",  {15'd0, RegWrite_MEMWB}, 16'h0);
    check("rst_halt_err",  {14'd0, Halt_MEMWB, err_MEMWB}, 16'h0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();

    // ALU op
    RegWrite_EXMEM = 1'b1; RegisterRd_EXMEM = 3'd3; ALU_Out_EXMEM = 16'h1234;
    @(negedge clk);
    check("alu_stall", {15'd0, stall_mem}, 16'h0);
    tick();
    check("alu_rd",       {13'd0, RegisterRd_MEMWB}, 16'd3);
    check("alu_wb_data",  wb_data_MEMWB,             16'h1234);
    check("alu_regwrite", {15'd0, RegWrite_MEMWB},   16'h1);

    // pc_to_reg selects the link value
    pc_to_reg_EXMEM = 1'b1; pcAdd2_EXMEM = 16'h0102; RegisterRd_EXMEM = 3'd7;
    tick();
    check("jal_wb_data", wb_data_MEMWB, 16'h0102);
    clear_inputs();

    // Load at 0x0040 with done three cycles later
    MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    RegisterRd_EXMEM = 3'd5; ALU_Out_EXMEM = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_stall", {15'd0, stall_mem}, 16'h1);
      check("ld_rd",    {15'd0, dmem_rd},   16'h1);
      check("ld_addr",  dmem_addr,          16'h0040);
      tick();
      check("ld_bubble", {15'd0, RegWrite_MEMWB}, 16'h0);
    end
    dmem_done = 1'b1; dmem_rdata = 16'hBEEF;
    @(negedge clk);
    check("ld_done_stall", {15'd0, stall_mem}, 16'h0);
    tick();
    check("ld_wb_data",  wb_data_MEMWB,           16'hBEEF);
    check("ld_regwrite", {15'd0, RegWrite_MEMWB}, 16'h1);
    check("ld_rd_memwb", {13'd0, RegisterRd_MEMWB}, 16'd5);
    clear_inputs();

    // Store completing the same cycle
    MemWrite_EXMEM = 1'b1; ALU_Out_EXMEM = 16'h0088; read2Data_EXMEM = 16'hA5A5;
    dmem_done = 1'b1;
    @(negedge clk);
    check("st_wr",    {15'd0, dmem_wr},   16'h1);
    check("st_addr",  dmem_addr,          16'h0088);
    check("st_wdata", dmem_wdata,         16'hA5A5);
    check("st_stall", {15'd0, stall_mem}, 16'h0);
    tick();
    check("st_regwrite", {15'd0, RegWrite_MEMWB}, 16'h0);
    clear_inputs();
    @(negedge clk);
    check("st_wr_drop", {15'd0, dmem_wr}, 16'h0);
    tick();

    // Load that never completes -> timeout
    MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    ALU_Out_EXMEM = 16'h0200;
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_mem) break;
      stall_cnt++;
      tick();
    end
    check("to_stall_cycles", 16'(stall_cnt), 16'd15);
    check("to_req_dropped", {15'd0, dmem_rd}, 16'h0);
    tick();
    check("to_err",      {15'd0, err_MEMWB},      16'h1);
    check("to_regwrite", {15'd0, RegWrite_MEMWB}, 16'h0);
    check("to_halt",     {15'd0, Halt_MEMWB},     16'h0);
    @(negedge clk);
    check("to_halted_rd",    {15'd0, dmem_rd},   16'h0);
    check("to_halted_stall", {15'd0, stall_mem}, 16'h0);
    clear_inputs();
    do_reset();

    // Halt with MemWrite: no access, halt retires, outputs freeze
    Halt_EXMEM = 1'b1; MemWrite_EXMEM = 1'b1; ALU_Out_EXMEM = 16'h5555;
    RegisterRd_EXMEM = 3'd2;
    @(negedge clk);
    check("halt_no_wr", {15'd0, dmem_wr}, 16'h0);
    tick();
    check("halt_retired", {15'd0, Halt_MEMWB}, 16'h1);
    check("halt_wb_data", wb_data_MEMWB,       16'h5555);
    clear_inputs();
    RegWrite_EXMEM = 1'b1; ALU_Out_EXMEM = 16'h7777; RegisterRd_EXMEM = 3'd6;
    tick();
    tick();
    check("halt_frozen_data", wb_data_MEMWB,           16'h5555);
    check("halt_frozen_rw",   {15'd0, RegWrite_MEMWB}, 16'h0);
    check("halt_frozen_h",    {15'd0, Halt_MEMWB},     16'h1);
    clear_inputs();
    do_reset();

    // Load a value, then reset mid-BUSY
    RegWrite_EXMEM = 1'b1; ALU_Out_EXMEM = 16'h4321; RegisterRd_EXMEM = 3'd1;
    tick();
    clear_inputs();
    MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    ALU_Out_EXMEM = 16'h0300;
    tick();
    tick();
    #1;
    check("pre_rst_rd", {15'd0, dmem_rd}, 16'h1);
    rst = 1'b0;
    #1;
    check("arst_rd",      {15'd0, dmem_rd},   16'h0);
    check("arst_stall",   {15'd0, stall_mem}, 16'h0);
    check("arst_wb_data", wb_data_MEMWB,      16'h0);
    check("arst_rd_memwb", {13'd0, RegisterRd_MEMWB}, 16'd0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    // Fresh from IDLE: a zero-wait load completes without stalling
    MemRead_EXMEM = 1'b1; MemtoReg_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1;
    ALU_Out_EXMEM = 16'h0010; dmem_done = 1'b1; dmem_rdata = 16'hCAFE;
    @(negedge clk);
    check("post_rst_stall", {15'd0, stall_mem}, 16'h0);
    tick();
    check("post_rst_wb", wb_data_MEMWB, 16'hCAFE);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles one data-memory access may stay outstanding.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset): one clock; reset is asynchronous and active-low.
REQ-003 SHALL have EX/MEM-side inputs, one per line, name direction width meaning:
- ALU_Out_EXMEM  in  16  memory address or ALU result.
- pcAdd2_EXMEM  in  16  link value for jump-and-link.
- read2Data_EXMEM  in  16  store data.
- RegisterRd_EXMEM  in  3  destination register.
- MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, RegWrite_EXMEM, pc_to_reg_EXMEM, Halt_EXMEM, err_EXMEM  in  1 each  stage controls and the upstream error.
REQ-004 SHALL have data-memory ports:
- dmem_addr  out  16  access address.
- dmem_wdata  out  16  store data.
- dmem_rd  out  1  read request.
- dmem_wr  out  1  write request.
- dmem_rdata  in  16  read data.
- dmem_done  in  1  access complete.
- dmem_err  in  1  access fault.
REQ-005 SHALL have pipeline outputs:
- stall_mem  out  1  deassert EX/MEM and all upstream enables.
- wb_data_MEMWB  out  16  write-back value.
- RegisterRd_MEMWB  out  3  destination register.
- RegWrite_MEMWB  out  1  register-file write enable.
- Halt_MEMWB  out  1  halt retired.
- err_MEMWB  out  1  error retired.

Function
REQ-006 SHALL run an FSM with states IDLE, BUSY and HALTED.
REQ-007 SHALL define access = (MemRead_EXMEM | MemWrite_EXMEM) & ~Halt_EXMEM & ~err_EXMEM, and SHALL not issue a memory request in HALTED.
REQ-008 IDLE or BUSY with access: SHALL drive dmem_rd = MemRead_EXMEM and dmem_wr = MemWrite_EXMEM as levels, with dmem_addr = ALU_Out_EXMEM and dmem_wdata = read2Data_EXMEM; they SHALL be 0 otherwise.
REQ-009 SHALL assert stall_mem = access & ~dmem_done combinationally in IDLE or BUSY; stall_mem SHALL be 0 in HALTED.
REQ-010 IDLE with access and ~dmem_done: SHALL go to BUSY and clear the cycle counter.
REQ-011 IDLE with access and dmem_done (zero-wait hit): SHALL stay in IDLE with no stall.
REQ-012 BUSY: the counter SHALL increment each cycle; on dmem_done the FSM SHALL return to IDLE.
REQ-013 BUSY timeout: when the counter reaches MEM_TIMEOUT-1 without dmem_done, the block SHALL drop requests and stall_mem and go to HALTED.
REQ-014 On the timeout edge, the MEM/WB register SHALL load err_MEMWB=1, RegWrite_MEMWB=0, Halt_MEMWB=0.
REQ-015 Normal load, when stall_mem=0 in IDLE or BUSY: wb_data_MEMWB SHALL be pcAdd2_EXMEM if pc_to_reg_EXMEM, else dmem_rdata if MemtoReg_EXMEM, else ALU_Out_EXMEM. RegisterRd, RegWrite, Halt and err SHALL copy from EX/MEM, with err ORed with dmem_err when access.
REQ-016 If err_MEMWB would load as 1, RegWrite_MEMWB SHALL load 0.
REQ-017 When stall_mem=1, the MEM/WB register SHALL load a bubble: RegWrite, Halt and err all 0; data and Rd may hold.
REQ-018 The FSM SHALL enter HALTED on the edge that loads Halt_MEMWB=1 or err_MEMWB=1.
REQ-019 In HALTED, the MEM/WB register SHALL hold its value and the block SHALL stay in HALTED until reset.
REQ-020 Halt_EXMEM with MemRead or MemWrite SHALL make no memory access.
REQ-021 Counter width SHALL be $clog2(MEM_TIMEOUT)+1; the counter SHALL saturate and never wrap.

Reset
REQ-022 rst low SHALL asynchronously force state IDLE, counter 0, and every MEM/WB output to 0.
REQ-023 During reset, dmem_rd, dmem_wr and stall_mem SHALL be 0.
REQ-024 Reset asserted while in BUSY SHALL abandon the access; no MEM/WB write SHALL occur.
REQ-025 After release, the first rising edge SHALL evaluate from IDLE.

Structure
REQ-026 The state enum and the default MEM_TIMEOUT SHALL live in the shared pipeline package.
REQ-027 The MEM/WB register bank SHALL be one sub-module, memwb_reg: async active-low reset, load enable, bubble input.
REQ-028 The FSM, counter and write-back mux SHALL live in mem_wb_stage.

Verification
REQ-029 ALU op: RegWrite=1, Rd=3, ALU_Out=0x1234, no memory access -> next edge Rd_MEMWB=3, wb_data=0x1234, RegWrite_MEMWB=1, stall_mem never 1.
REQ-030 Load at 0x0040, dmem_done 3 cycles later with rdata 0xBEEF -> stall_mem high 3 cycles, bubbles in MEM/WB, then wb_data=0xBEEF, RegWrite_MEMWB=1.
REQ-031 Store with dmem_done same cycle -> dmem_wr=1 one cycle, addr and wdata match inputs, no stall, RegWrite_MEMWB=0.
REQ-032 Load with dmem_done never asserted, MEM_TIMEOUT=16 -> stall_mem for 15 cycles, then err_MEMWB=1, RegWrite_MEMWB=0, state HALTED, no further requests.
REQ-033 Halt_EXMEM=1 with MemWrite=1 -> no dmem_wr, Halt_MEMWB=1, outputs frozen afterwards.
REQ-034 rst low mid-BUSY -> all outputs 0 immediately (async), dmem_rd drops, FSM IDLE after release.
